fetch_queue: RTL

- Instruction-fetch buffer between the PC generator and the fetch/decode pipeline register.
- Issues in-order instruction-memory reads at the current fetch PC (PCF) and buffers returned {pc, instr} pairs in a small FIFO.
- Presents buffered pairs to decode with a valid/ready handshake and drives the PC hold signal (stall_f).
- On an execute-stage redirect, flushes buffered entries and squashes in-flight responses.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/fetch_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN  = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous clear.
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch buffer: issues in-order imem reads at PCF, queues {pc, instr} for decode.
// Optional same-cycle bypass to decode when the queue is empty: define FETCH_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pcf,
  input  logic                  flush,
  output logic                  stall_f,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [DATA_WIDTH-1:0] dec_pc,
  output logic [DATA_WIDTH-1:0] dec_pc_plus4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]           count, outstanding;
  logic [CW-1:0]           drop_cnt_q, drop_cnt_d;
  logic [CW:0]             reserved;
  logic                    issue, rsp_live, rsp_keep, bypass, q_push, q_pop;
  logic [DATA_WIDTH-1:0]   infl_pc;
  logic [2*DATA_WIDTH-1:0] q_rdata;

  // Queue slots are reserved at issue time, so responses never need backpressure.
  assign reserved       = {1'b0, count} + {1'b0, outstanding} - {1'b0, drop_cnt_q};
  assign imem_req_valid = rst & ~flush & (reserved < (CW+1)'(DEPTH));
  assign imem_addr      = pcf;
  assign issue          = imem_req_valid & imem_req_ready;
  assign stall_f        = ~rst | (~flush & ~issue);

  assign rsp_live = imem_rsp_valid & (outstanding != '0);
  assign rsp_keep = rsp_live & (drop_cnt_q == '0) & ~flush;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep & (count == '0) & dec_ready;
`else
  assign bypass = 1'b0;
`endif

  assign q_push    = rsp_keep & ~bypass;
  assign q_pop     = (count != '0) & ~flush & dec_ready;
  assign dec_valid = ((count != '0) & ~flush) | bypass;

  always_comb begin
    dec_pc    = q_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    dec_instr = q_rdata[DATA_WIDTH-1:0];
    if (bypass) begin
      dec_pc    = infl_pc;
      dec_instr = imem_rsp_data;
    end
    dec_pc_plus4 = rst ? dec_pc + DATA_WIDTH'(INSTR_BYTES) : '0;
  end

  // Every request still in flight at a redirect is stale, including ones already marked.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = outstanding - CW'(rsp_live);
    end else if (rsp_live && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(
    .Width(DATA_WIDTH),
    .Depth(DEPTH)
  ) u_infl (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (1'b0),
    .push_i (issue),
    .wdata_i(pcf),
    .pop_i  (rsp_live),
    .rdata_o(infl_pc),
    .count_o(outstanding)
  );

  sync_fifo #(
    .Width(2 * DATA_WIDTH),
    .Depth(DEPTH)
  ) u_queue (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (flush),
    .push_i (q_push),
    .wdata_i({infl_pc, imem_rsp_data}),
    .pop_i  (q_pop),
    .rdata_o(q_rdata),
    .count_o(count)
  );

`ifndef SYNTHESIS
  a_rsp_has_req : assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (outstanding != '0))
    else $error("imem response with no request outstanding");
`endif

endmodule
